// File: rtl/serv_ibus_responder.sv
// ---------------------------------------------------------------------------
// serv_ibus_responder
//
// Wishbone classic instruction-bus responder for the SERV fetch port. It holds
// a loadable word-wide program store and answers each fetch after LATENCY
// wait states. Misaligned or out-of-range fetches return TRAP_INSN and set a
// sticky error flag.
//
// Ports:
//   clk             - single clock, rising edge
//   i_rst_n         - asynchronous active-low reset
//   i_wb_ibus_adr   - byte address of the fetch
//   i_wb_ibus_cyc   - fetch request, held until ack or abort
//   o_wb_ibus_rdt   - instruction word, qualify with ack
//   o_wb_ibus_ack   - one-cycle acknowledge
//   i_ld_en         - program-store write strobe
//   i_ld_adr        - word index to write
//   i_ld_dat        - word to write
//   o_err           - sticky invalid-fetch flag, cleared only by reset
//   o_fetch_cnt     - wrapping count of acknowledged fetches
// ---------------------------------------------------------------------------
module serv_ibus_responder #(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 0,
    parameter logic [31:0] TRAP_INSN = 32'h00100073
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic [31:0]              i_wb_ibus_adr,
    input  logic                     i_wb_ibus_cyc,
    output logic [31:0]              o_wb_ibus_rdt,
    output logic                     o_wb_ibus_ack,
    input  logic                     i_ld_en,
    input  logic [$clog2(DEPTH)-1:0] i_ld_adr,
    input  logic [31:0]              i_ld_dat,
    output logic                     o_err,
    output logic [15:0]              o_fetch_cnt
);

    localparam int AW = $clog2(DEPTH);

    // Value loaded into the wait counter on acceptance; unused when LATENCY=0.
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_cnt_nxt;
    logic [31:0] r_adr;
    logic [31:0] r_rdt;
    logic        r_ack;
    logic        r_err;
    logic [15:0] r_fetch_cnt;

    logic [31:0] w_fetch_adr;
    logic        w_valid;
    logic [AW-1:0] w_idx;
    logic        w_enter_ack;

    logic [31:0] r_mem [DEPTH];

    // Program store write port. It runs regardless of the fetch FSM and is
    // never reset, so contents are undefined until loaded.
    always_ff @(posedge clk) begin
        if (i_ld_en) begin
            r_mem[i_ld_adr] <= i_ld_dat;
        end
    end

    // With LATENCY=0 the ACK-entry edge is also the acceptance edge, so the
    // address has not been latched yet and must come straight off the bus.
    always_comb begin
        w_fetch_adr = (r_state == IDLE) ? i_wb_ibus_adr : r_adr;
        w_valid     = (w_fetch_adr[1:0] == 2'b00) && (w_fetch_adr[31:AW+2] == '0);
        w_idx       = w_fetch_adr[AW+1:2];
    end

    // Next-state logic for the fetch handshake. A dropped cyc during WAIT is
    // an abort and returns to IDLE without any side effects.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (i_wb_ibus_cyc) begin
                    if (LATENCY == 0) begin
                        w_state_nxt = ACK;
                    end else begin
                        w_state_nxt    = WAIT;
                        w_wait_cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!i_wb_ibus_cyc) begin
                    w_state_nxt = IDLE;
                end else if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = ACK;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_enter_ack = (w_state_nxt == ACK);
    end

    // State, latched address and response registers. The store is read on
    // the ACK-entry edge, so a load landing on that same edge is not seen
    // (non-blocking read-before-write) while earlier loads during WAIT are.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_wait_cnt  <= 4'd0;
            r_adr       <= 32'd0;
            r_rdt       <= 32'd0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_fetch_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_ack      <= w_enter_ack;
            if ((r_state == IDLE) && i_wb_ibus_cyc) begin
                r_adr <= i_wb_ibus_adr;
            end
            if (w_enter_ack) begin
                r_rdt       <= w_valid ? r_mem[w_idx] : TRAP_INSN;
                r_err       <= r_err | ~w_valid;
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
        end
    end

    assign o_wb_ibus_rdt = r_rdt;
    assign o_wb_ibus_ack = r_ack;
    assign o_err         = r_err;
    assign o_fetch_cnt   = r_fetch_cnt;

endmodule

// File: tb/tb_serv_ibus_responder.sv
// ---------------------------------------------------------------------------
// tb_serv_ibus_responder
//
// Drives two responders sharing one load port and reset: index 0 has zero
// wait states, index 1 has three. A small reference model (program array,
// per-instance error flag and fetch count) predicts every response from the
// address rules, and the cycle at which ack should appear is derived from
// the wait-state count alone.
// ---------------------------------------------------------------------------
module tb_serv_ibus_responder;

    localparam int          DEPTH = 256;
    localparam int          LAT0  = 0;
    localparam int          LAT1  = 3;
    localparam logic [31:0] TRAP  = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc [2];
    logic [31:0] adr [2];
    logic [31:0] rdt [2];
    logic        ack [2];
    logic        err [2];
    logic [15:0] cnt [2];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_adr = 8'd0;
    logic [31:0] ld_dat = 32'd0;

    int          tests_run = 0;
    int          tests_failed = 0;

    logic [31:0] model_mem [DEPTH];
    logic        model_err [2];
    int          model_cnt [2];

    always #5 clk = ~clk;

    serv_ibus_responder #(.DEPTH(DEPTH), .LATENCY(LAT0), .TRAP_INSN(TRAP)) u_dut0 (
        .clk(clk), .i_rst_n(rst_n),
        .i_wb_ibus_adr(adr[0]), .i_wb_ibus_cyc(cyc[0]),
        .o_wb_ibus_rdt(rdt[0]), .o_wb_ibus_ack(ack[0]),
        .i_ld_en(ld_en), .i_ld_adr(ld_adr), .i_ld_dat(ld_dat),
        .o_err(err[0]), .o_fetch_cnt(cnt[0])
    );

    serv_ibus_responder #(.DEPTH(DEPTH), .LATENCY(LAT1), .TRAP_INSN(TRAP)) u_dut1 (
        .clk(clk), .i_rst_n(rst_n),
        .i_wb_ibus_adr(adr[1]), .i_wb_ibus_cyc(cyc[1]),
        .o_wb_ibus_rdt(rdt[1]), .o_wb_ibus_ack(ack[1]),
        .i_ld_en(ld_en), .i_ld_adr(ld_adr), .i_ld_dat(ld_dat),
        .o_err(err[1]), .o_fetch_cnt(cnt[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    // A fetch is bad when not word aligned or when its word number is past
    // the end of the store.
    function automatic logic addr_bad(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] expect_word(input logic [31:0] a);
        logic [7:0] wi;
        wi = 8'(a / 4);
        return addr_bad(a) ? TRAP : model_mem[wi];
    endfunction

    // Writes one store word through the shared load port (both instances).
    task automatic load_word(input int idx, input logic [31:0] dat);
        ld_en  = 1'b1;
        ld_adr = idx[7:0];
        ld_dat = dat;
        @(posedge clk); #1;
        ld_en  = 1'b0;
        model_mem[idx[7:0]] = dat;
    endtask

    // Issues one fetch starting in the current cycle (cycle 0), holds cyc until
    // ack, reports the cycle number in which ack was seen (-1 on timeout) and
    // whether ack was still high one cycle later. Leaves the FSM back in IDLE.
    task automatic do_fetch(input int d, input logic [31:0] a,
                            output logic [31:0] got, output int lat_cycles,
                            output logic ack_after);
        got        = 32'd0;
        lat_cycles = -1;
        cyc[d]     = 1'b1;
        adr[d]     = a;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ack[d]) begin
                lat_cycles = n;
                got        = rdt[d];
                break;
            end
        end
        cyc[d] = 1'b0;
        @(posedge clk); #1;
        ack_after = ack[d];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if ((ack[d] !== 1'b0) || (rdt[d] !== 32'd0) || (err[d] !== 1'b0) || (cnt[d] !== 16'd0)) begin
                tests_failed++;
                $display("[TB] FAIL reset_state dut%0d: ack=%b rdt=%h err=%b cnt=%0d, required all zero",
                         d, ack[d], rdt[d], err[d], cnt[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) begin
            load_word(i, $urandom);
        end
        load_word(0, 32'h0000006F);
        load_word(3, 32'h00000013);
    endtask

    // Basic fetch on each instance with the prescribed words.
    task automatic test_basic();
        logic [31:0] got;
        int          lc;
        logic        aa;
        do_fetch(0, 32'h0000000C, got, lc, aa);
        model_cnt[0]++;
        tests_run++;
        if ((got !== 32'h00000013) || (lc != LAT0 + 1) || (aa !== 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL basic_lat0: rdt=%h at cycle %0d ack_after=%b, required %h at %0d ack_after=0",
                     got, lc, aa, 32'h00000013, LAT0 + 1);
        end
        tests_run++;
        if ((cnt[0] !== 16'd1) || (err[0] !== 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL basic_lat0_status: cnt=%0d err=%b, required cnt=1 err=0", cnt[0], err[0]);
        end
        do_fetch(1, 32'h00000000, got, lc, aa);
        model_cnt[1]++;
        tests_run++;
        if ((got !== 32'h0000006F) || (lc != LAT1 + 1) || (aa !== 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL basic_lat3: rdt=%h at cycle %0d ack_after=%b, required %h at %0d ack_after=0",
                     got, lc, aa, 32'h0000006F, LAT1 + 1);
        end
        tests_run++;
        if ((cnt[1] !== 16'd1) || (err[1] !== 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL basic_lat3_status: cnt=%0d err=%b, required cnt=1 err=0", cnt[1], err[1]);
        end
    endtask

    // Out-of-range, misaligned and last-valid-word fetches.
    task automatic test_invalid();
        logic [31:0] addrs [4];
        int          dsel  [4];
        logic [31:0] got;
        logic [31:0] expw;
        int          lc;
        logic        aa;
        addrs = '{32'h00000400, 32'h00000006, 32'h000003FC, 32'h00000401};
        dsel  = '{1, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            expw = expect_word(addrs[i]);
            do_fetch(dsel[i], addrs[i], got, lc, aa);
            model_cnt[dsel[i]]++;
            model_err[dsel[i]] = model_err[dsel[i]] | addr_bad(addrs[i]);
            tests_run++;
            if ((got !== expw) || (lc != lat_of(dsel[i]) + 1)) begin
                tests_failed++;
                $display("[TB] FAIL invalid_rdt adr=%h: rdt=%h cycle %0d, required %h cycle %0d",
                         addrs[i], got, lc, expw, lat_of(dsel[i]) + 1);
            end
            tests_run++;
            if ((err[dsel[i]] !== model_err[dsel[i]]) || (cnt[dsel[i]] !== 16'(model_cnt[dsel[i]]))) begin
                tests_failed++;
                $display("[TB] FAIL invalid_status adr=%h: err=%b cnt=%0d, required err=%b cnt=%0d",
                         addrs[i], err[dsel[i]], cnt[dsel[i]], model_err[dsel[i]], model_cnt[dsel[i]]);
            end
        end
    endtask

    // Abort during WAIT on the three-wait-state instance, then a normal fetch.
    task automatic test_abort();
        logic        seen;
        logic [31:0] got;
        logic [31:0] expw;
        int          lc;
        logic        aa;
        seen   = 1'b0;
        cyc[1] = 1'b1;
        adr[1] = 32'h00000008;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | ack[1];
        end
        cyc[1] = 1'b0;
        repeat (LAT1 + 3) begin
            @(posedge clk); #1;
            seen = seen | ack[1];
        end
        tests_run++;
        if ((seen !== 1'b0) || (cnt[1] !== 16'(model_cnt[1]))) begin
            tests_failed++;
            $display("[TB] FAIL abort: ack_seen=%b cnt=%0d, required ack_seen=0 cnt=%0d",
                     seen, cnt[1], model_cnt[1]);
        end
        expw = expect_word(32'h00000008);
        do_fetch(1, 32'h00000008, got, lc, aa);
        model_cnt[1]++;
        tests_run++;
        if ((got !== expw) || (lc != LAT1 + 1) || (cnt[1] !== 16'(model_cnt[1]))) begin
            tests_failed++;
            $display("[TB] FAIL after_abort: rdt=%h cycle %0d cnt=%0d, required %h cycle %0d cnt=%0d",
                     got, lc, cnt[1], expw, LAT1 + 1, model_cnt[1]);
        end
    endtask

    // Loads racing a fetch: one during WAIT (seen), one on the ACK-entry edge
    // (not seen), then a plain fetch that sees the late load.
    task automatic test_load_race(input int d);
        int          lat;
        int          ld_cycle;
        int          n_seen;
        logic [31:0] got;
        logic [31:0] new_word;
        logic [31:0] exp_old;
        logic        aa;
        lat = lat_of(d);
        for (int pass = 0; pass < 2; pass++) begin
            // pass 0: load inside WAIT (only meaningful with wait states)
            if ((pass == 0) && (lat == 0)) continue;
            ld_cycle = (pass == 0) ? 1 : lat;
            new_word = $urandom;
            exp_old  = model_mem[5];
            n_seen   = -1;
            got      = 32'd0;
            cyc[d]   = 1'b1;
            adr[d]   = 32'h00000014;
            for (int n = 0; n < 40; n++) begin
                if (n == ld_cycle) begin
                    ld_en  = 1'b1;
                    ld_adr = 8'd5;
                    ld_dat = (pass == 0) ? 32'h30200073 : new_word;
                end else begin
                    ld_en = 1'b0;
                end
                @(posedge clk); #1;
                if (n == ld_cycle) begin
                    model_mem[5] = ld_dat;
                end
                if (ack[d]) begin
                    n_seen = n + 1;
                    got    = rdt[d];
                    break;
                end
            end
            ld_en  = 1'b0;
            cyc[d] = 1'b0;
            model_cnt[d]++;
            @(posedge clk); #1;
            tests_run++;
            if (pass == 0) begin
                if ((got !== 32'h30200073) || (n_seen != lat + 1)) begin
                    tests_failed++;
                    $display("[TB] FAIL load_in_wait dut%0d: rdt=%h cycle %0d, required %h cycle %0d",
                             d, got, n_seen, 32'h30200073, lat + 1);
                end
            end else begin
                if ((got !== exp_old) || (n_seen != lat + 1)) begin
                    tests_failed++;
                    $display("[TB] FAIL load_same_edge dut%0d: rdt=%h cycle %0d, required old %h cycle %0d",
                             d, got, n_seen, exp_old, lat + 1);
                end
            end
        end
        do_fetch(d, 32'h00000014, got, n_seen, aa);
        model_cnt[d]++;
        tests_run++;
        if (got !== model_mem[5]) begin
            tests_failed++;
            $display("[TB] FAIL load_visible_later dut%0d: rdt=%h, required %h", d, got, model_mem[5]);
        end
    endtask

    // cyc held high across three fetches: acks must be L+2 cycles apart.
    task automatic test_back_to_back();
        int          ack_cycles [$];
        logic [31:0] expw;
        logic        bad_rdt;
        expw    = expect_word(32'h00000010);
        bad_rdt = 1'b0;
        cyc[1]  = 1'b1;
        adr[1]  = 32'h00000010;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ack[1]) begin
                ack_cycles.push_back(n);
                if (rdt[1] !== expw) bad_rdt = 1'b1;
                if (ack_cycles.size() == 3) begin
                    cyc[1] = 1'b0;
                    break;
                end
            end
        end
        cyc[1] = 1'b0;
        @(posedge clk); #1;
        model_cnt[1] += ack_cycles.size();
        tests_run++;
        if ((ack_cycles.size() != 3) || bad_rdt) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_count: acks=%0d bad_rdt=%b, required 3 acks with %h",
                     ack_cycles.size(), bad_rdt, expw);
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (ack_cycles[k] != (LAT1 + 1) + k * (LAT1 + 2)) begin
                    tests_failed++;
                    $display("[TB] FAIL back_to_back_timing ack%0d: cycle %0d, required %0d",
                             k, ack_cycles[k], (LAT1 + 1) + k * (LAT1 + 2));
                end
            end
        end
        tests_run++;
        if (cnt[1] !== 16'(model_cnt[1])) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_cnt: cnt=%0d, required %0d", cnt[1], model_cnt[1]);
        end
    endtask

    // Randomised fetches over both instances with occasional reloads.
    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int          d;
            int          kind;
            int          lc;
            logic [31:0] a;
            logic [31:0] got;
            logic [31:0] expw;
            logic        aa;
            logic        bad;
            d    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
                1:       a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
                2:       a = 32'($urandom_range(DEPTH, 100000)) * 4;
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                load_word(int'($urandom_range(0, DEPTH - 1)), $urandom);
            end
            bad  = addr_bad(a);
            expw = expect_word(a);
            do_fetch(d, a, got, lc, aa);
            model_cnt[d]++;
            model_err[d] = model_err[d] | bad;
            tests_run++;
            if ((got !== expw) || (lc != lat_of(d) + 1) || (aa !== 1'b0)) begin
                tests_failed++;
                $display("[TB] FAIL random_fetch dut%0d adr=%h: rdt=%h cycle %0d ack_after=%b, required %h cycle %0d ack_after=0",
                         d, a, got, lc, aa, expw, lat_of(d) + 1);
            end
            tests_run++;
            if ((err[d] !== model_err[d]) || (cnt[d] !== 16'(model_cnt[d]))) begin
                tests_failed++;
                $display("[TB] FAIL random_status dut%0d adr=%h: err=%b cnt=%0d, required err=%b cnt=%0d",
                         d, a, err[d], cnt[d], model_err[d], model_cnt[d]);
            end
        end
    endtask

    // Asynchronous reset while the three-wait-state instance is mid-WAIT.
    task automatic test_reset_mid_wait();
        logic [31:0] got;
        logic [31:0] expw;
        int          lc;
        logic        aa;
        cyc[1] = 1'b1;
        adr[1] = 32'h00000010;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if ((ack[d] !== 1'b0) || (rdt[d] !== 32'd0) || (err[d] !== 1'b0) || (cnt[d] !== 16'd0)) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_wait dut%0d: ack=%b rdt=%h err=%b cnt=%0d, required all zero",
                         d, ack[d], rdt[d], err[d], cnt[d]);
            end
        end
        cyc[1] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        model_err[0] = 1'b0;
        model_err[1] = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (ack[1] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL dropped_fetch: ack=%b after reset release, required 0", ack[1]);
        end
        expw = expect_word(32'h00000010);
        do_fetch(1, 32'h00000010, got, lc, aa);
        model_cnt[1]++;
        tests_run++;
        if ((got !== expw) || (lc != LAT1 + 1) || (cnt[1] !== 16'(model_cnt[1])) || (err[1] !== 1'b0)) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_fetch: rdt=%h cycle %0d cnt=%0d err=%b, required %h cycle %0d cnt=%0d err=0",
                     got, lc, cnt[1], err[1], expw, LAT1 + 1, model_cnt[1]);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            cyc[d]       = 1'b0;
            adr[d]       = 32'd0;
            model_err[d] = 1'b0;
            model_cnt[d] = 0;
        end
        test_reset();
        preload();
        test_basic();
        test_invalid();
        test_abort();
        test_load_race(1);
        test_load_race(0);
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
